muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the RV32M multiply/divide datapath in the EX stage.
//  - Accepts one M-extension op from EX.
//  - Runs a 1-cycle registered multiply or an iterative restoring divide.
//  - Asserts a stall to the hazard logic until the result is ready.
//  - Returns the result with a one-cycle valid pulse for the EX->MEM register.

---
 rtl/muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer: RV32M multiply/divide sequencer for the EX stage.
// A registered one-cycle multiply and an iterative restoring divide
// (DIV_STEPS quotient bits per cycle), with a stall to the hazard logic and a
// one-cycle result-valid pulse toward the EX->MEM register.
// Optional feature: define MULDIV_RESULT_CACHE_EN to remember the last
// completed divide so a matching DIV/REM follow-up finishes in one cycle.
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int DIV_CYCLES = XLEN / DIV_STEPS;
    localparam int CNT_W      = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [1:0]       op_q;          // funct3[1:0] of the op in flight
    logic [XLEN-1:0]  quo_q, rem_q, dsr_q;
    logic             neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? negate(v) : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    // Accept decode and divide special cases, evaluated on the raw operands
    logic            accept, in_is_div, in_signed_div, in_div_zero, in_div_ovf, in_special;
    logic            cache_hit;
    logic [XLEN-1:0] special_res, cache_res;

    assign accept        = (state_q == S_IDLE) && i_valid && !i_flush;
    assign in_is_div     = i_funct3[2];
    assign in_signed_div = !i_funct3[0];
    assign in_div_zero   = (i_rs2_val == '0);
    assign in_div_ovf    = in_signed_div && (i_rs1_val == INT_MIN) && (i_rs2_val == '1);
    assign in_special    = in_is_div && (in_div_zero || in_div_ovf);
    assign special_res   = in_div_zero ? (i_funct3[1] ? i_rs1_val : '1)
                                       : (i_funct3[1] ? '0 : INT_MIN);

    // 33x33 signed product, computed modulo 2^64 on sign/zero-extended operands
    logic                   mul_a_signed, mul_b_signed;
    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]        mul_res;

    assign mul_a_signed = (op_q != 2'd3);
    assign mul_b_signed = !op_q[1];
    assign mul_a   = {{XLEN{mul_a_signed & rs1_q[XLEN-1]}}, rs1_q};
    assign mul_b   = {{XLEN{mul_b_signed & rs2_q[XLEN-1]}}, rs2_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring divide: DIV_STEPS shift/subtract iterations on the magnitudes
    logic [XLEN-1:0] quo_it, rem_it, quo_fin, rem_fin, div_res;

    always_comb begin
        logic [XLEN:0] rem_sh;
        logic [XLEN:0] diff;
        quo_it = quo_q;
        rem_it = rem_q;
        rem_sh = '0;
        diff   = '0;
        for (int i = 0; i < DIV_STEPS; i++) begin
            rem_sh = {rem_it, quo_it[XLEN-1]};
            diff   = rem_sh - {1'b0, dsr_q};
            // diff's top bit is the borrow: set means the trial subtract failed
            rem_it = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            quo_it = {quo_it[XLEN-2:0], !diff[XLEN]};
        end
    end

    assign quo_fin = apply_sign(quo_it, neg_quo_q);
    assign rem_fin = apply_sign(rem_it, neg_rem_q);
    assign div_res = op_q[1] ? rem_fin : quo_fin;

`ifdef MULDIV_RESULT_CACHE_EN
    logic            c_vld_q, c_uns_q, div_uns_q;
    logic [XLEN-1:0] c_rs1_q, c_rs2_q, c_quo_q, c_rem_q;

    assign cache_hit = in_is_div && c_vld_q && (c_rs1_q == i_rs1_val) &&
                       (c_rs2_q == i_rs2_val) && (c_uns_q == i_funct3[0]);
    assign cache_res = i_funct3[1] ? c_rem_q : c_quo_q;

    // Record the last divide that ran to completion; aborted runs leave it untouched
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            c_vld_q   <= 1'b0;
            c_uns_q   <= 1'b0;
            div_uns_q <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
        end else begin
            if (accept)
                div_uns_q <= i_funct3[0];
            if (state_q == S_DIV && !i_flush && cnt_q == '0) begin
                c_vld_q <= 1'b1;
                c_uns_q <= div_uns_q;
                c_rs1_q <= rs1_q;
                c_rs2_q <= rs2_q;
                c_quo_q <= quo_fin;
                c_rem_q <= rem_fin;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and handshake outputs; a flushed op neither stalls nor completes
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_stall = 1'b0;
        o_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                o_stall = accept;
                if (accept) begin
                    if (!in_is_div)
                        state_d = S_MUL;
                    else if (in_special || cache_hit)
                        state_d = S_DONE;
                    else
                        state_d = S_DIV;
                end
            end
            S_MUL: begin
                o_stall = !i_flush;
                state_d = i_flush ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                o_stall = !i_flush;
                if (i_flush)
                    state_d = S_IDLE;
                else if (cnt_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                o_valid = !i_flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, divide iteration and result register (loaded only on entry to DONE)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            op_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q     <= i_rs1_val;
                        rs2_q     <= i_rs2_val;
                        op_q      <= i_funct3[1:0];
                        quo_q     <= magnitude(i_rs1_val, in_signed_div);
                        rem_q     <= '0;
                        dsr_q     <= magnitude(i_rs2_val, in_signed_div);
                        neg_quo_q <= in_signed_div && (i_rs1_val[XLEN-1] ^ i_rs2_val[XLEN-1]);
                        neg_rem_q <= in_signed_div && i_rs1_val[XLEN-1];
                        cnt_q     <= CNT_LAST;
                        if (in_special)
                            result_q <= special_res;
                        else if (cache_hit)
                            result_q <= cache_res;
                    end
                end
                S_MUL: begin
                    if (!i_flush)
                        result_q <= mul_res;
                end
                S_DIV: begin
                    if (!i_flush) begin
                        quo_q <= quo_it;
                        rem_q <= rem_it;
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == '0)
                            result_q <= div_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Testbench for muldiv_sequencer: directed ops checked cycle-by-cycle against
// an arithmetic/latency model, plus literal expected results per op.
module tb_muldiv_sequencer;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 1;
    localparam int DIV_LAT   = XLEN / DIV_STEPS + 1;
`ifdef MULDIV_RESULT_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = DIV_LAT;
`endif
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        o_ready, o_stall, o_valid;
    logic [31:0] o_result;

    muldiv_sequencer #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .i_funct3  (funct3),
        .i_rs1_val (rs1),
        .i_rs2_val (rs2),
        .i_flush   (i_flush),
        .o_ready   (o_ready),
        .o_stall   (o_stall),
        .o_valid   (o_valid),
        .o_result  (o_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Model of the op in flight: accept cycle, valid cycle, kill cycle, result
    bit          m_act = 1'b0;
    int          m_start = 0;
    int          m_done = 0;
    int          m_kill = NEVER;
    logic [31:0] m_res = '0;
    bit          checking = 1'b0;
    bit          got_valid = 1'b0;
    int          got_cyc = 0;
    logic [31:0] got_res = '0;

`ifdef MULDIV_RESULT_CACHE_EN
    bit          m_store = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_uns = 1'b0;
    bit          c_vld = 1'b0;
    logic [31:0] c_a = '0, c_b = '0;
    bit          c_uns = 1'b0;
`endif

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          ia, ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_RESULT_CACHE_EN
        if (c_vld && c_a == a && c_b == b && c_uns == f3[0]) return 1;
`endif
        return DIV_LAT;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle-by-cycle comparison of the handshake and result against the model
    always @(negedge clk) begin
        int e_end;
        bit e_stall, e_busy, e_valid;
        if (checking) begin
            e_end   = (m_kill < m_done) ? m_kill : m_done;
            e_stall = m_act && cyc >= m_start && cyc < e_end;
            e_busy  = m_act && cyc > m_start && cyc <= e_end;
            e_valid = m_act && cyc == m_done && m_kill > m_done;
            chk("o_stall", o_stall, e_stall);
            chk("o_ready", o_ready, !e_busy);
            chk("o_valid", o_valid, e_valid);
            if (e_valid) chk("o_result", o_result, m_res);
            if (o_valid) begin
                got_valid = 1'b1;
                got_cyc   = cyc;
                got_res   = o_result;
            end
`ifdef MULDIV_RESULT_CACHE_EN
            if (e_valid && m_store) begin
                c_vld = 1'b1;
                c_a   = m_a;
                c_b   = m_b;
                c_uns = m_uns;
            end
`endif
        end
    end

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        funct3    = f3;
        rs1       = a;
        rs2       = b;
        i_valid   = 1'b1;
        got_valid = 1'b0;
        m_act     = 1'b1;
        m_start   = cyc;
        m_done    = cyc + ref_latency(f3, a, b);
        m_kill    = NEVER;
        m_res     = ref_result(f3, a, b);
`ifdef MULDIV_RESULT_CACHE_EN
        m_store = f3[2] && (ref_latency(f3, a, b) == DIV_LAT);
        m_a     = a;
        m_b     = b;
        m_uns   = f3[0];
`endif
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lit_lat);
        int t0, waited;
        start_op(f3, a, b);
        t0     = m_start;
        waited = 0;
        while (!got_valid && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!got_valid) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, " result"}, got_res, lit);
            chk({name, " latency"}, got_cyc - t0, lit_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset o_ready", o_ready, 1);
        chk("reset o_stall", o_stall, 0);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_result", o_result, 0);
        checking = 1'b1;

        // Multiplies
        do_op("mul 7*-3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        do_op("mulhu ff*ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        do_op("mulhsu ff*ff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        do_op("mulh ff*ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        do_op("mul ff*ff",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);

        // Signed divide and remainder
        do_op("div -20/3",     3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT);
        do_op("rem -20/3",     3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, HIT_LAT);

        // Special cases
        do_op("divu 5/0",      3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem 5/0",       3'd6, 32'd5, 32'd0, 32'd5, 1);
        do_op("div ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Iterative divides, including cache-hit follow-ups
        do_op("div 100/7",     3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT);
        do_op("rem 100/7",     3'd6, 32'd100, 32'd7, 32'd2, HIT_LAT);
        do_op("rem 100/9",     3'd6, 32'd100, 32'd9, 32'd1, DIV_LAT);
        do_op("divu big/16",   3'd5, 32'hFFFF_FFF0, 32'd16, 32'h0FFF_FFFF, DIV_LAT);
        do_op("remu big/16",   3'd7, 32'hFFFF_FFF0, 32'd16, 32'd0, HIT_LAT);
        do_op("div 7/-2",      3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        do_op("rem 7/-2",      3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, HIT_LAT);
        do_op("rem -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        do_op("div min/1",     3'd4, 32'h8000_0000, 32'd1, 32'h8000_0000, DIV_LAT);
        do_op("divu min/ff",   3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LAT);

        // Flush mid-divide at T+10
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        i_flush = 1'b1;
        m_kill  = cyc;
        @(posedge clk); #1;
        i_flush = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("flush no valid", got_valid, 0);
        do_op("div after flush", 3'd4, 32'd1000, 32'd3, 32'd333, DIV_LAT);

        // i_valid and i_flush together in IDLE: nothing accepted
        @(posedge clk); #1;
        funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
        i_valid = 1'b1; i_flush = 1'b1;
        @(negedge clk);
        chk("valid+flush o_stall", o_stall, 0);
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        chk("valid+flush o_ready", o_ready, 1);
        chk("valid+flush o_valid", o_valid, 0);

        // Reset in the middle of a divide
        start_op(3'd4, 32'h7FFF_FFFF, 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        checking = 1'b0;
        rst_n    = 1'b0;
        m_kill   = cyc;
`ifdef MULDIV_RESULT_CACHE_EN
        c_vld = 1'b0;
`endif
        @(posedge clk); #1;
        rst_n    = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        chk("mid-op reset o_result", o_result, 0);
        chk("mid-op reset o_ready", o_ready, 1);
        repeat (40) @(posedge clk);
        #1 chk("reset no valid", got_valid, 0);
        do_op("rem after reset", 3'd6, 32'd1000, 32'd3, 32'd1, DIV_LAT);
        do_op("mul recover",     3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 2);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
